// File: rtl/ham_frame_acc_pkg.sv
// Shared types and constants for the frame weight accumulator.
package ham_frame_acc_pkg;

   typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

   localparam int MAX_WEIGHT = 32;
   localparam int WEIGHT_W   = 6;

endpackage

// File: rtl/ham_frame_acc_if.sv
// Weight-in / frame-result-out stream bundle between popcount stage and report logic.
interface ham_frame_acc_if
   import ham_frame_acc_pkg::*;
#(
   parameter int IN_W  = 32,
   parameter int ACC_W = 16,
   parameter int CNT_W = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [IN_W-1:0]     in_cnt;
   logic                in_last;
   logic                out_valid;
   logic                out_ready;
   logic [ACC_W-1:0]    out_sum;
   logic [CNT_W-1:0]    out_words;
   logic [WEIGHT_W-1:0] out_max;
   logic                out_sat;
   logic                out_err;

   modport master (
      output in_valid, in_cnt, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_words, out_max, out_sat, out_err
   );

   modport slave (
      input  in_valid, in_cnt, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_words, out_max, out_sat, out_err
   );
endinterface

// File: rtl/ham_frame_acc_sat_add.sv
// Unsigned saturating adder; sat flags that the true sum did not fit in W bits.
module sat_add #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum,
   output logic         sat
);
   logic [W:0] full;

   always_comb begin
      full = {1'b0, a} + {1'b0, b};
      sat  = full[W];
      sum  = full[W] ? {W{1'b1}} : full[W-1:0];
   end
endmodule

// File: rtl/ham_frame_acc.sv
// Per-frame accumulator of Hamming weights: total, word count and maximum,
// held on a valid/ready result port until accepted.
module ham_frame_acc
   import ham_frame_acc_pkg::*;
#(
   parameter int IN_W  = 32,
   parameter int ACC_W = 16,
   parameter int CNT_W = 8
) (
   input  logic           clk,
   input  logic           rst,
   ham_frame_acc_if.slave bus
);
   state_e              state_q, state_d;
   logic [ACC_W-1:0]    sum_q, sum_d, sum_base, sum_add;
   logic [CNT_W-1:0]    words_q, words_d, words_base, words_add;
   logic [WEIGHT_W-1:0] max_q, max_d, w;
   logic                sat_q, sat_d, err_q, err_d;
   logic                illegal, beat, first, sum_sat, words_sat;

   // Upper in_cnt bits only feed the range check; an illegal beat weighs 0.
   assign illegal = bus.in_cnt > IN_W'(MAX_WEIGHT);
   assign w       = illegal ? '0 : bus.in_cnt[WEIGHT_W-1:0];
   assign beat    = bus.in_valid && (state_q != OUT);
   assign first   = (state_q == IDLE);

   assign sum_base   = first ? '0 : sum_q;
   assign words_base = first ? '0 : words_q;

   sat_add #(.W(ACC_W)) u_sum (
      .a(sum_base), .b(ACC_W'(w)), .sum(sum_add), .sat(sum_sat)
   );

   sat_add #(.W(CNT_W)) u_words (
      .a(words_base), .b(CNT_W'(1)), .sum(words_add), .sat(words_sat)
   );

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      words_d = words_q;
      max_d   = max_q;
      sat_d   = sat_q;
      err_d   = err_q;
      case (state_q)
         IDLE, ACC: begin
            if (beat) begin
               sum_d   = sum_add;
               words_d = words_add;
               max_d   = (first || (w > max_q)) ? w : max_q;
               sat_d   = (sat_q && !first) || sum_sat || words_sat;
               err_d   = (err_q && !first) || illegal;
               state_d = bus.in_last ? OUT : ACC;
            end
         end
         OUT: begin
            if (bus.out_ready) begin
               state_d = IDLE;
               sum_d   = '0;
               words_d = '0;
               max_d   = '0;
               sat_d   = 1'b0;
               err_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sum_q   <= '0;
         words_q <= '0;
         max_q   <= '0;
         sat_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         words_q <= words_d;
         max_q   <= max_d;
         sat_q   <= sat_d;
         err_q   <= err_d;
      end
   end

   // Result fields are masked so a partially built frame never leaks out.
   assign bus.in_ready  = (state_q != OUT);
   assign bus.out_valid = (state_q == OUT);
   assign bus.out_sum   = bus.out_valid ? sum_q   : '0;
   assign bus.out_words = bus.out_valid ? words_q : '0;
   assign bus.out_max   = bus.out_valid ? max_q   : '0;
   assign bus.out_sat   = bus.out_valid && sat_q;
   assign bus.out_err   = bus.out_valid && err_q;
endmodule

// File: tb/tb_ham_frame_acc.sv
// Scoreboard bench: a 16-bit-accumulator instance and a 6-bit one driven frame by frame.
module tb_ham_frame_acc;
   import ham_frame_acc_pkg::*;

   typedef struct {
      int sum;
      int words;
      int mx;
      bit sat;
      bit err;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;

   ham_frame_acc_if #(.IN_W(32), .ACC_W(16), .CNT_W(8)) bif0 ();
   ham_frame_acc_if #(.IN_W(32), .ACC_W(6),  .CNT_W(8)) bif1 ();

   ham_frame_acc #(.IN_W(32), .ACC_W(16), .CNT_W(8)) u_dut0 (.clk(clk), .rst(rst), .bus(bif0));
   ham_frame_acc #(.IN_W(32), .ACC_W(6),  .CNT_W(8)) u_dut1 (.clk(clk), .rst(rst), .bus(bif1));

   function automatic exp_t model(input int acc_w, input int ws[$]);
      exp_t e;
      longint lim;
      int w;
      e = '{default: 0};
      lim = (longint'(1) << acc_w) - 1;
      foreach (ws[i]) begin
         w = (ws[i] > MAX_WEIGHT) ? 0 : ws[i];
         if (ws[i] > MAX_WEIGHT) e.err = 1'b1;
         if (longint'(e.sum) + w > lim) begin e.sum = int'(lim); e.sat = 1'b1; end
         else e.sum = e.sum + w;
         if (e.words == 255) e.sat = 1'b1; else e.words++;
         if (w > e.mx) e.mx = w;
      end
      return e;
   endfunction

   task automatic drive(input int sel, input logic v, input logic [31:0] cnt, input logic last);
      if (sel == 0) begin bif0.in_valid = v; bif0.in_cnt = cnt; bif0.in_last = last; end
      else          begin bif1.in_valid = v; bif1.in_cnt = cnt; bif1.in_last = last; end
   endtask

   task automatic set_ready(input int sel, input logic r);
      if (sel == 0) bif0.out_ready = r; else bif1.out_ready = r;
   endtask

   task automatic snap(input int sel, output logic rdy, output logic ov,
                       output logic [31:0] s, output logic [31:0] wd, output logic [31:0] m,
                       output logic sat, output logic err);
      if (sel == 0) begin
         rdy = bif0.in_ready; ov = bif0.out_valid; s = 32'(bif0.out_sum);
         wd = 32'(bif0.out_words); m = 32'(bif0.out_max); sat = bif0.out_sat; err = bif0.out_err;
      end else begin
         rdy = bif1.in_ready; ov = bif1.out_valid; s = 32'(bif1.out_sum);
         wd = 32'(bif1.out_words); m = 32'(bif1.out_max); sat = bif1.out_sat; err = bif1.out_err;
      end
   endtask

   // Presents one beat at a negedge and returns #1 after the edge that took it.
   task automatic send_beat(input int sel, input int cnt, input bit last);
      logic rdy, ov, sat, err;
      logic [31:0] s, wd, m;
      int n = 0;
      @(negedge clk);
      drive(sel, 1'b1, 32'(cnt), last);
      snap(sel, rdy, ov, s, wd, m, sat, err);
      while (rdy !== 1'b1 && n < 20) begin
         @(negedge clk);
         snap(sel, rdy, ov, s, wd, m, sat, err);
         n++;
      end
      if (rdy !== 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL in_ready_timeout dut%0d: in_ready=%b, required 1", sel, rdy);
      end else begin
         @(posedge clk);
         #1;
      end
      drive(sel, 1'b0, 32'd0, 1'b0);
   endtask

   task automatic send_frame(input int sel, input int ws[$]);
      foreach (ws[i]) send_beat(sel, ws[i], i == ws.size() - 1);
      if (sel == 0) q0.push_back(model(16, ws)); else q1.push_back(model(6, ws));
   endtask

   // Waits (bounded) for a result and compares it against the scoreboard head.
   task automatic collect(input int sel, input string name, input int maxw);
      logic rdy, ov, sat, err;
      logic [31:0] s, wd, m;
      exp_t e;
      int n = 0;
      @(negedge clk);
      snap(sel, rdy, ov, s, wd, m, sat, err);
      while (ov !== 1'b1 && n < maxw) begin
         @(negedge clk);
         snap(sel, rdy, ov, s, wd, m, sat, err);
         n++;
      end
      n_cmp++;
      if (ov !== 1'b1) begin
         n_bad++;
         $display("FAIL %s out_valid: got %b, required 1 within %0d cycles", name, ov, maxw);
      end else if ((sel == 0 ? q0.size() : q1.size()) == 0) begin
         n_bad++;
         $display("FAIL %s scoreboard: result seen with no expected entry", name);
      end else begin
         e = (sel == 0) ? q0.pop_front() : q1.pop_front();
         n_cmp++; if (s !== 32'(e.sum))   begin n_bad++; $display("FAIL %s out_sum: got %0d, required %0d", name, s, e.sum); end
         n_cmp++; if (wd !== 32'(e.words)) begin n_bad++; $display("FAIL %s out_words: got %0d, required %0d", name, wd, e.words); end
         n_cmp++; if (m !== 32'(e.mx))    begin n_bad++; $display("FAIL %s out_max: got %0d, required %0d", name, m, e.mx); end
         n_cmp++; if (sat !== e.sat)      begin n_bad++; $display("FAIL %s out_sat: got %b, required %b", name, sat, e.sat); end
         n_cmp++; if (err !== e.err)      begin n_bad++; $display("FAIL %s out_err: got %b, required %b", name, err, e.err); end
         n_cmp++; if (rdy !== 1'b0)       begin n_bad++; $display("FAIL %s in_ready_in_out: got %b, required 0", name, rdy); end
      end
   endtask

   task automatic test_reset();
      logic rdy, ov, sat, err;
      logic [31:0] s, wd, m;
      rst = 1'b1;
      drive(0, 1'b0, 32'd0, 1'b0); drive(1, 1'b0, 32'd0, 1'b0);
      set_ready(0, 1'b1); set_ready(1, 1'b1);
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         snap(d, rdy, ov, s, wd, m, sat, err);
         n_cmp++;
         if (rdy !== 1'b1 || ov !== 1'b0 || s !== 0 || wd !== 0 || m !== 0 || sat !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state dut%0d: rdy=%b ov=%b sum=%0d words=%0d max=%0d sat=%b err=%b, required 1 0 0 0 0 0 0",
                     d, rdy, ov, s, wd, m, sat, err);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      logic rdy, ov, sat, err;
      logic [31:0] s, wd, m;
      int ws[$];
      send_beat(0, 16, 1'b0);
      send_beat(0, 16, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      snap(0, rdy, ov, s, wd, m, sat, err);
      n_cmp++;
      if (rdy !== 1'b1 || ov !== 1'b0 || s !== 0) begin
         n_bad++;
         $display("FAIL mid_reset: rdy=%b ov=%b sum=%0d, required 1 0 0", rdy, ov, s);
      end
      @(negedge clk);
      rst = 1'b0;
      ws = {8};
      send_frame(0, ws);
      collect(0, "after_reset", 0);
   endtask

   task automatic test_three_word();
      logic rdy, ov, sat, err;
      logic [31:0] s, wd, m;
      int ws[$];
      ws = {16, 32, 0};
      send_frame(0, ws);
      collect(0, "three_word", 0);
      @(negedge clk);
      snap(0, rdy, ov, s, wd, m, sat, err);
      n_cmp++;
      if (ov !== 1'b0 || rdy !== 1'b1 || s !== 0) begin
         n_bad++;
         $display("FAIL back_to_idle: ov=%b rdy=%b sum=%0d, required 0 1 0", ov, rdy, s);
      end
   endtask

   task automatic test_backpressure();
      logic rdy, ov, sat, err;
      logic [31:0] s, wd, m;
      int ws[$];
      set_ready(0, 1'b0);
      ws = {16};
      send_frame(0, ws);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         snap(0, rdy, ov, s, wd, m, sat, err);
         n_cmp++;
         if (ov !== 1'b1 || rdy !== 1'b0 || s !== 16 || wd !== 1 || m !== 16) begin
            n_bad++;
            $display("FAIL hold_cycle%0d: ov=%b rdy=%b sum=%0d words=%0d max=%0d, required 1 0 16 1 16",
                     i, ov, rdy, s, wd, m);
         end
      end
      collect(0, "backpressure", 0);
      set_ready(0, 1'b1);
      @(negedge clk);
      snap(0, rdy, ov, s, wd, m, sat, err);
      n_cmp++;
      if (ov !== 1'b0 || rdy !== 1'b1) begin
         n_bad++;
         $display("FAIL release: ov=%b rdy=%b, required 0 1", ov, rdy);
      end
   endtask

   task automatic test_saturation();
      int ws[$];
      ws = {32, 32, 32};
      send_frame(1, ws);
      collect(1, "sum_sat", 0);
      ws = {1};
      send_frame(1, ws);
      collect(1, "sat_clears", 0);
      ws = {};
      for (int i = 0; i < 256; i++) ws.push_back(0);
      send_frame(0, ws);
      collect(0, "words_sat", 0);
   endtask

   task automatic test_illegal();
      int ws[$];
      ws = {5, 40, 7};
      send_frame(0, ws);
      collect(0, "illegal", 0);
      ws = {1};
      send_frame(0, ws);
      collect(0, "err_clears", 0);
      ws = {32, 33};
      send_frame(0, ws);
      collect(0, "illegal_33", 0);
   endtask

   task automatic test_gapped();
      logic rdy, ov, sat, err;
      logic [31:0] s, wd, m;
      send_beat(0, 3, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         snap(0, rdy, ov, s, wd, m, sat, err);
         n_cmp++;
         if (rdy !== 1'b1 || ov !== 1'b0) begin
            n_bad++;
            $display("FAIL gap_cycle%0d: rdy=%b ov=%b, required 1 0", i, rdy, ov);
         end
      end
      send_beat(0, 4, 1'b1);
      q0.push_back(model(16, {3, 4}));
      collect(0, "gapped", 0);
   endtask

   initial begin
      test_reset();
      test_reset_mid_frame();
      test_three_word();
      test_backpressure();
      test_saturation();
      test_illegal();
      test_gapped();
      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/ham_frame_acc.md
Name: ham_frame_acc

Overview:
Downstream consumer of the 32-bit population-count stage. Takes one per-word Hamming weight per beat over a valid/ready stream, framed by a last flag. Accumulates each frame into a total weight, a word count and a maximum weight, then holds the result on a valid/ready output until it is accepted. Sits between the popcount stage and the result/report logic.

Parameters:
IN_W, 32, width of the incoming weight bus; matches the popcount stage output width.
ACC_W, 16, width of the total-weight accumulator.
CNT_W, 8, width of the word counter.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  weight beat valid
in_ready  output  1  block can accept a beat
in_cnt  input  IN_W  Hamming weight of one word; legal range 0..32
in_last  input  1  beat is the final word of the frame
out_valid  output  1  frame result valid
out_ready  input  1  consumer accepts the result
out_sum  output  ACC_W  total weight of the frame
out_words  output  CNT_W  number of words in the frame
out_max  output  6  largest legal weight in the frame
out_sat  output  1  out_sum or out_words saturated
out_err  output  1  at least one beat had in_cnt > 32

Behaviour:
- Reset is asynchronous and active-high. It is the only reset.
  - State returns to IDLE.
  - All accumulators and outputs go to 0; in_ready is 1 immediately.
  - A partial frame is discarded.
  - Reset dominates every other event in the same cycle.
- A beat is accepted when in_valid & in_ready are both high at a rising clk edge.
- States:
  - IDLE: no frame open. in_ready=1, out_valid=0.
  - ACC: frame open. in_ready=1, out_valid=0.
  - OUT: result held. in_ready=0, out_valid=1.
- Transitions:
  - IDLE, accepted beat: load sum=w, words=1, max=w. Go to OUT if in_last, else to ACC.
  - ACC, accepted beat: sum+=w, words+=1, max=max(max,w). Go to OUT if in_last.
  - ACC, no beat: hold; there is no timeout.
  - OUT & out_ready: go to IDLE and clear the accumulators on the same edge.
  - OUT & !out_ready: hold all outputs stable (backpressure).
- Latency: out_valid rises on the edge that accepts the in_last beat, so it is visible in the following cycle.
- No overlap: in_ready=0 while in OUT. The cycle that accepts out_ready cannot also accept an input beat, so there is one bubble per frame.
- Illegal weights:
  - If in_cnt > 32, the effective weight w is 0. The beat is still counted in words.
  - out_err is set and stays sticky for the rest of the frame.
  - Upper bits of in_cnt above bit 5 take part only in the >32 check.
- Arithmetic and saturation:
  - All arithmetic is unsigned.
  - sum saturates at 2^ACC_W-1 and sets out_sat.
  - words saturates at 2^CNT_W-1 and sets out_sat.
  - out_sat is sticky for the rest of the frame.
- out_sum, out_words, out_max, out_sat and out_err all read 0 outside OUT.
- Inputs arriving while in_ready=0 are ignored and must not be lost upstream; upstream holds them per the handshake.

Decomposition:
- Shared package holds:
  - state enum {IDLE, ACC, OUT}.
  - constant MAX_WEIGHT=32.
  - constant WEIGHT_W=6.
- One sub-module is natural: sat_add. It is a parameterised-width unsigned saturating adder with a saturation flag output.
  - Instantiate it once for sum (width ACC_W).
  - Instantiate it once for words (width CNT_W, incrementing by 1).

Test Plan:
- Reset mid-frame: rst pulses after 2 beats (16,16) -> all outputs 0 immediately, in_ready=1. Next frame of 8 with last -> out_sum=8, out_words=1.
- Three-word frame (16,32,0 with last), out_ready=1 -> one cycle after last: out_valid=1, out_sum=48, out_words=3, out_max=32, out_sat=0, out_err=0. Next cycle back in IDLE.
- Backpressure: single-beat frame 16 with last, out_ready=0 for 5 cycles -> outputs stable at 16/1/16 and in_ready=0 throughout. Raising out_ready returns to IDLE one edge later.
- Saturation with ACC_W=6 and beats 32,32,32 (last) -> out_sum=63, out_words=3, out_sat=1.
- Illegal weight: beats 5, 40, 7 (last) -> out_sum=12, out_words=3, out_max=7, out_err=1. The following frame of 1 (last) -> out_err=0.
- Gapped input: beats 3, then in_valid low for 4 cycles, then 4 (last) -> state holds in ACC during the gap; result out_sum=7, out_words=2.
